// File: rtl/bus_pkg.sv
// bus_pkg: shared snoop-bus types.
//   bus_op_t    - snoop bus operation encoding, also imported by cores/caches
//   arb_state_t - arbiter FSM state
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GRANT   = 2'b01,
    ARB_RELEASE = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin winner selection.
//   req    - request vector, one bit per core
//   rr_ptr - last owner; the search starts at rr_ptr+1 and wraps
//   valid  - at least one request present
//   winner - index of the first requester found from rr_ptr+1
module rr_priority_picker #(
  parameter  int NUM_CORES = 4,
  localparam int IW        = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IW-1:0]        rr_ptr,
  output logic                 valid,
  output logic [IW-1:0]        winner
);

  int idx;

  // rr_ptr itself is visited last, so the core that just released loses
  // every tie.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CORES;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner arbitration for a shared snoop bus.
//   clk, reset          - system clock, async active-high reset
//   req_core            - per-core request, held for the whole transaction
//   bus_operation_in    - per-core op (bus_op_t encoding)
//   bus_address_in/data - per-core address / data
//   flush_in            - per-core writeback toward L2
//   cache_hit_in        - per-core snoop hit
//   grant, bus_owner    - registered one-hot grant and owner index
//   bus_*_out           - owner's transaction broadcast while in GRANT
//   cache_hit_out       - OR of non-owner snoop hits while in GRANT
//   l2_wr_en            - owner's flush while in GRANT
//   hold_timeout        - sticky: an owner held the bus MAX_HOLD cycles
//                         while someone else was waiting
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int NUM_CORES = 4,
  parameter  int MAX_HOLD  = 16,
  localparam int IW        = $clog2(NUM_CORES),
  localparam int HW        = $clog2(MAX_HOLD + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             req_core,
  input  logic [NUM_CORES-1:0][1:0]        bus_operation_in,
  input  logic [NUM_CORES-1:0][BUS_AW-1:0] bus_address_in,
  input  logic [NUM_CORES-1:0][BUS_DW-1:0] bus_data_in,
  input  logic [NUM_CORES-1:0]             flush_in,
  input  logic [NUM_CORES-1:0]             cache_hit_in,
  output logic [NUM_CORES-1:0]             grant,
  output logic [1:0]                       bus_operation_out,
  output logic [BUS_AW-1:0]                bus_address_out,
  output logic [BUS_DW-1:0]                bus_data_out,
  output logic                             cache_hit_out,
  output logic                             l2_wr_en,
  output logic [IW-1:0]                    bus_owner,
  output logic                             hold_timeout
);

  arb_state_t     state;
  logic [IW-1:0]  rr_ptr;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_nxt;
  logic           pick_valid;
  logic [IW-1:0]  pick_idx;
  logic           others_req;

  rr_priority_picker #(.NUM_CORES(NUM_CORES)) u_picker (
    .req    (req_core),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Saturating next value of the hold counter.
  assign hold_nxt   = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
  // grant is the owner one-hot while in GRANT, so this masks the owner out.
  assign others_req = |(req_core & ~grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB_IDLE;
      grant        <= '0;
      bus_owner    <= '0;
      rr_ptr       <= IW'(NUM_CORES - 1);
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant     <= {{(NUM_CORES-1){1'b0}}, 1'b1} << pick_idx;
            bus_owner <= pick_idx;
            hold_cnt  <= '0;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!req_core[bus_owner]) begin
            grant  <= '0;
            rr_ptr <= bus_owner;
            state  <= ARB_RELEASE;
          end else begin
            hold_cnt <= hold_nxt;
            // Flag only; the owner keeps the bus.
            if (hold_nxt == HW'(MAX_HOLD) && others_req)
              hold_timeout <= 1'b1;
          end
        end
        ARB_RELEASE: state <= ARB_IDLE;
        default: begin
          grant <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Broadcast mux off the registered owner; reset forces IDLE and with it
  // the idle bus values.
  always_comb begin
    bus_operation_out = BUS_NON;
    bus_address_out   = '0;
    bus_data_out      = '0;
    cache_hit_out     = 1'b0;
    l2_wr_en          = 1'b0;
    if (state == ARB_GRANT) begin
      bus_operation_out = bus_operation_in[bus_owner];
      bus_address_out   = bus_address_in[bus_owner];
      bus_data_out      = bus_data_in[bus_owner];
      cache_hit_out     = |(cache_hit_in & ~grant);
      l2_wr_en          = flush_in[bus_owner];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int MH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0][1:0] op_in;
  logic [N-1:0][31:0] addr_in, data_in;
  logic [N-1:0]      flush, hit_in;
  logic [N-1:0]      grant;
  logic [1:0]        op_out;
  logic [31:0]       addr_out, data_out;
  logic              hit_out, l2_wr_en, hold_timeout;
  logic [1:0]        bus_owner;

  bus_arbiter #(.NUM_CORES(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req_core(req), .bus_operation_in(op_in),
    .bus_address_in(addr_in), .bus_data_in(data_in), .flush_in(flush),
    .cache_hit_in(hit_in), .grant(grant), .bus_operation_out(op_out),
    .bus_address_out(addr_out), .bus_data_out(data_out),
    .cache_hit_out(hit_out), .l2_wr_en(l2_wr_en), .bus_owner(bus_owner),
    .hold_timeout(hold_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the bus, whether a turnaround is pending,
  // how long the owner has held it.
  int m_own, m_last, m_rr, m_held;
  bit m_turn, m_to;

  task automatic model_reset();
    m_own = -1; m_last = 0; m_rr = N - 1; m_held = 0; m_turn = 0; m_to = 0;
  endtask

  task automatic model_edge();
    if (m_turn) m_turn = 0;
    else if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (m_own < 0 && req[c]) begin
          m_own = c; m_last = c; m_held = 0;
        end
      end
    end else if (!req[m_own]) begin
      m_rr = m_own; m_own = -1; m_turn = 1;
    end else begin
      if (m_held < MH) m_held++;
      if (m_held == MH && (req & ~(4'(1) << m_own)) != 0) m_to = 1;
    end
  endtask

  task automatic cmp_all(string tag);
    logic [3:0] eg; logic [1:0] eo; logic [31:0] ea, ed; logic eh, el;
    eg = '0; eo = 2'b11; ea = '0; ed = '0; eh = 1'b0; el = 1'b0;
    if (m_own >= 0) begin
      eg = 4'(1) << m_own;
      eo = op_in[m_own]; ea = addr_in[m_own]; ed = data_in[m_own];
      el = flush[m_own];
      for (int i = 0; i < N; i++) if (i != m_own && hit_in[i]) eh = 1'b1;
    end
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".owner"}, 32'(bus_owner), 32'(m_last));
    chk({tag, ".op"}, 32'(op_out), 32'(eo));
    chk({tag, ".addr"}, addr_out, ea);
    chk({tag, ".data"}, data_out, ed);
    chk({tag, ".hit"}, 32'(hit_out), 32'(eh));
    chk({tag, ".l2"}, 32'(l2_wr_en), 32'(el));
    chk({tag, ".timeout"}, 32'(hold_timeout), 32'(m_to));
  endtask

  // One clock: advance the model with the inputs the DUT will sample,
  // then compare a little after the edge.
  task automatic cyc(string tag);
    model_edge();
    @(posedge clk); #2;
    cmp_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; flush = '0; hit_in = '0;
    op_in = '0; addr_in = '0; data_in = '0;
    @(posedge clk); @(posedge clk); #2;
    model_reset();
    chk("rst.grant", 32'(grant), 0);
    chk("rst.op", 32'(op_out), 32'h3);
    chk("rst.owner", 32'(bus_owner), 0);
    chk("rst.timeout", 32'(hold_timeout), 0);
    cmp_all("rst");
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
  } vec_t;
  vec_t tbl[20];

  initial begin
    // req applied before the edge -> grant/owner expected after it
    tbl[0]  = '{4'b1111, 4'b0001, 2'd0};
    tbl[1]  = '{4'b1110, 4'b0000, 2'd0};
    tbl[2]  = '{4'b1110, 4'b0000, 2'd0};
    tbl[3]  = '{4'b1110, 4'b0010, 2'd1};
    tbl[4]  = '{4'b1100, 4'b0000, 2'd1};
    tbl[5]  = '{4'b1100, 4'b0000, 2'd1};
    tbl[6]  = '{4'b1100, 4'b0100, 2'd2};
    tbl[7]  = '{4'b1000, 4'b0000, 2'd2};
    tbl[8]  = '{4'b1000, 4'b0000, 2'd2};
    tbl[9]  = '{4'b1000, 4'b1000, 2'd3};
    tbl[10] = '{4'b0111, 4'b0000, 2'd3};
    tbl[11] = '{4'b0111, 4'b0000, 2'd3};
    tbl[12] = '{4'b0111, 4'b0001, 2'd0};
    tbl[13] = '{4'b0110, 4'b0000, 2'd0};
    tbl[14] = '{4'b0111, 4'b0000, 2'd0};
    tbl[15] = '{4'b0111, 4'b0010, 2'd1};
    tbl[16] = '{4'b0101, 4'b0000, 2'd1};
    tbl[17] = '{4'b0101, 4'b0000, 2'd1};
    tbl[18] = '{4'b0101, 4'b0100, 2'd2};
    tbl[19] = '{4'b0001, 4'b0000, 2'd2};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      req = tbl[i].req;
      cyc("tbl");
      chk($sformatf("tbl%0d.grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d.owner", i), 32'(bus_owner), 32'(tbl[i].owner));
    end

    // Core 2 owns: broadcast and snoop-hit masking
    do_reset();
    req = 4'b0100; op_in[2] = 2'b10; addr_in[2] = 32'h40;
    op_in[0] = 2'b01; addr_in[0] = 32'h1234; hit_in = 4'b0100;
    cyc("c2");
    chk("c2.grant", 32'(grant), 32'h4);
    chk("c2.op", 32'(op_out), 32'h2);
    chk("c2.addr", addr_out, 32'h40);
    chk("c2.hit_own", 32'(hit_out), 0);
    hit_in = 4'b0001; #1;
    chk("c2.hit_other", 32'(hit_out), 1);

    // Core 1 owns: flush forwarding, then release
    do_reset();
    req = 4'b0010; flush = 4'b0011;
    data_in[1] = 32'hDEADBEEF; data_in[0] = 32'h11111111;
    cyc("c1");
    chk("c1.l2", 32'(l2_wr_en), 1);
    chk("c1.data", data_out, 32'hDEADBEEF);
    req = 4'b0000;
    cyc("c1rel");
    chk("c1rel.grant", 32'(grant), 0);
    chk("c1rel.l2", 32'(l2_wr_en), 0);
    chk("c1rel.op", 32'(op_out), 32'h3);

    // Hold watchdog: core 0 holds 20 cycles while core 3 waits
    do_reset();
    req = 4'b1001;
    cyc("hold");
    chk("hold.grant0", 32'(grant), 32'h1);
    for (int c = 1; c <= 20; c++) begin
      cyc("hold");
      chk($sformatf("hold%0d.flag", c), 32'(hold_timeout), 32'(c >= 16));
      chk($sformatf("hold%0d.grant", c), 32'(grant), 32'h1);
    end
    req = 4'b1000;
    cyc("hold_rel");
    chk("hold_rel.grant", 32'(grant), 0);
    chk("hold_rel.flag", 32'(hold_timeout), 1);
    cyc("hold_after"); cyc("hold_after");
    chk("hold_after.flag", 32'(hold_timeout), 1);

    // Async reset in the middle of GRANT
    do_reset();
    req = 4'b0001; op_in[0] = 2'b01;
    cyc("mid");
    chk("mid.grant", 32'(grant), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst.grant", 32'(grant), 0);
    chk("mid_rst.op", 32'(op_out), 32'h3);
    do_reset();
    req = 4'b0100;
    cyc("post_rst");
    chk("post_rst.grant", 32'(grant), 32'h4);

    // Randomized traffic against the model
    do_reset();
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ((m_own == i) ? ($urandom_range(7) == 0) : ($urandom_range(15) == 0))
            req[i] = 1'b0;
        end else if ($urandom_range(2) == 0) req[i] = 1'b1;
        op_in[i]   = 2'($urandom_range(3));
        addr_in[i] = $urandom;
        data_in[i] = $urandom;
      end
      flush  = 4'($urandom_range(15));
      hit_in = 4'($urandom_range(15));
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
